ram_read_scanner: RTL and testbench
===================================

// Module: ram_read_scanner
// PURPOSE
//  Drives the read port of the 32x4 dual-port RAM, replacing the free-running divider tap on the DE1 wrapper.
//  Sweeps read addresses at a programmable rate. Supports run/pause and single-step.
//  Aligns the RAM's registered read data with the address that produced it, giving the HEX displays a consistent addr/data pair.
// PARAMETERS
//  ADDR_WIDTH   5           read address width; sweep covers 0..2**ADDR_WIDTH-1
//  DATA_WIDTH   4           RAM data width
//  TICK_CYCLES  67_108_864  clk cycles per auto-advance (~0.75 Hz at 50 MHz); legal range >= 2
//  RD_LATENCY   1           RAM read latency in cycles, from rdaddress to q; legal 1..3
// PORTS
//  clk         in   1           system clock (CLOCK_50)
//  reset       in   1           asynchronous, active-low reset
//  run         in   1           level, pre-filtered; 1 = auto-advance, 0 = paused
//  step        in   1           level, pre-filtered button; rising edge advances one address while paused
//  rd_addr     out  ADDR_WIDTH  to RAM rdaddress
//  rd_data     in   DATA_WIDTH  from RAM q
//  disp_addr   out  ADDR_WIDTH  address whose data is on disp_data
//  disp_data   out  DATA_WIDTH  registered RAM data for display
//  disp_valid  out  1           disp_addr/disp_data pair is settled
//  sweep_done  out  1           one-cycle pulse on wrap from max address to 0
// BEHAVIOUR
//  Reset (reset==0, async): clears all registers immediately.
//   - rd_addr=0, disp_addr=0, disp_data=0, disp_valid=0, sweep_done=0.
//   - Tick timer=0, settle counter=RD_LATENCY+1.
//   - step_prev=1, so a step held through reset release does not advance.
//  Modes: RUNNING when run==1, PAUSED when run==0. Mode is re-evaluated every cycle.
//  RUNNING:
//   - Timer counts 0..TICK_CYCLES-1.
//   - At timer==TICK_CYCLES-1: assert advance; timer <= 0.
//   - The first advance after entering RUNNING lands on the TICK_CYCLES-th edge that samples run==1.
//  PAUSED:
//   - Timer is held at 0.
//   - Advance on a step rising edge (step==1 && step_prev==0): exactly one advance per press, regardless of hold time.
//  Gating and collisions:
//   - Step edges are ignored while run==1.
//   - Terminal count and a step edge in the same cycle produce one advance only.
//   - If run falls in the terminal-count cycle, no advance occurs (run is sampled in that cycle).
//  Advance:
//   - rd_addr <= rd_addr+1, modulo 2**ADDR_WIDTH.
//   - On wrap (max -> 0), sweep_done=1 for exactly the cycle in which rd_addr first reads 0.
//  Alignment pipeline (every cycle, not only on advance):
//   - addr_pipe[0] <= rd_addr; addr_pipe[i] <= addr_pipe[i-1].
//   - disp_data <= rd_data; disp_addr <= addr_pipe[RD_LATENCY-1].
//   - The pair therefore always matches. A RAM write to the displayed address shows within RD_LATENCY+1 cycles, with no advance needed.
//  disp_valid:
//   - Settle counter reloads to RD_LATENCY+1 on reset exit and on every advance.
//   - It decrements each cycle; disp_valid=1 iff the counter==0.
//   - Low for exactly RD_LATENCY+1 cycles after each advance.
//  No other state: the block never writes the RAM and has no backpressure.
// TESTING (bench: TICK_CYCLES=4, RD_LATENCY=1, RAM model with 1-cycle registered read, mem[i]=i^4'hA)
//  1 reset=0 for 3 cycles with step=1 -> all outputs 0 during reset; after release with step still high -> rd_addr stays 0; disp_valid=1 on 2nd edge after release.
//  2 run=1 from addr 0 -> rd_addr=1 on the 4th sampled edge, then +1 every 4 cycles; after each advance, disp_valid=0 for 2 cycles, then disp_addr=1, disp_data=4'hB.
//  3 run=1 through a full sweep -> rd_addr 31->0 after 128 cycles; sweep_done high exactly 1 cycle, coincident with rd_addr==0; no pulse at any other address.
//  4 run=0, three 1-cycle step pulses -> rd_addr=3; step held for 10 cycles -> rd_addr=4 only; 20 idle cycles -> no change.
//  5 paused at addr 4, bench writes mem[4]=4'h5 -> disp_data=4'h5 within 2 cycles; disp_addr stays 4; disp_valid stays 1.
//  6 running at rd_addr=7, pulse reset=0 mid-cycle -> rd_addr=0 before the next edge; after release, next advance exactly 4 edges later.

Source files
------------

// File: rtl/ram_read_scanner.sv
`default_nettype none
// ============================================================================
// Module  : ram_read_scanner
// Brief   : Sweeps the RAM read address (timed or single-step) and presents
//           an aligned, settled address/data pair for display.
// Revision: 1.0 - initial release
// ============================================================================
module ram_read_scanner #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 4,
  parameter int TICK_CYCLES = 67_108_864,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid,
  output logic                  sweep_done
);

  localparam int                    TIMER_W     = $clog2(TICK_CYCLES);
  localparam logic [TIMER_W-1:0]    TIMER_LAST  = TIMER_W'(TICK_CYCLES - 1);
  localparam int                    SETTLE_W    = $clog2(RD_LATENCY + 2);
  localparam logic [SETTLE_W-1:0]   SETTLE_INIT = SETTLE_W'(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX    = '1;

  logic [TIMER_W-1:0]                     timer_q, timer_d;
  logic [SETTLE_W-1:0]                    settle_q, settle_d;
  logic                                   step_prev_q, step_prev_d;
  logic [ADDR_WIDTH-1:0]                  rd_addr_q, rd_addr_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0]  addr_pipe_q, addr_pipe_d;
  logic [ADDR_WIDTH-1:0]                  disp_addr_q, disp_addr_d;
  logic [DATA_WIDTH-1:0]                  disp_data_q, disp_data_d;
  logic                                   sweep_done_q, sweep_done_d;
  logic                                   advance;

  always_comb begin
    advance      = 1'b0;
    timer_d      = '0;
    step_prev_d  = step;
    rd_addr_d    = rd_addr_q;
    sweep_done_d = 1'b0;
    settle_d     = (settle_q != '0) ? settle_q - SETTLE_W'(1) : '0;

    // Run gates the step edge; a falling run in the terminal cycle cancels the tick.
    if (run) begin
      if (timer_q == TIMER_LAST) begin
        advance = 1'b1;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end else begin
      advance = step && !step_prev_q;
    end

    if (advance) begin
      rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
      sweep_done_d = (rd_addr_q == ADDR_MAX);
      settle_d     = SETTLE_INIT;
    end

    addr_pipe_d[0] = rd_addr_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end
    disp_addr_d = addr_pipe_q[RD_LATENCY-1];
    disp_data_d = rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q      <= '0;
      settle_q     <= SETTLE_INIT;
      step_prev_q  <= 1'b1;
      rd_addr_q    <= '0;
      addr_pipe_q  <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      settle_q     <= settle_d;
      step_prev_q  <= step_prev_d;
      rd_addr_q    <= rd_addr_d;
      addr_pipe_q  <= addr_pipe_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = (settle_q == '0);
  assign sweep_done = sweep_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_read_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_read_scanner
// Brief   : Self-checking bench for ram_read_scanner with a 1-cycle RAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_read_scanner;

  localparam int AW   = 5;
  localparam int DW   = 4;
  localparam int TICK = 4;
  localparam int NADR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          step;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          sweep_done;

  logic [DW-1:0] mem [NADR];

  int  n_cmp = 0;
  int  n_err = 0;
  bit  chk_en = 1'b1;

  // Reference model state: counts and history, not the DUT's registers.
  int  m_addr;
  int  m_streak;
  int  m_since;
  bit  m_prev_step;
  bit  m_sweep;

  ram_read_scanner #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TICK_CYCLES(TICK),
    .RD_LATENCY (1)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr      = 0;
    m_streak    = 0;
    m_since     = 0;
    m_prev_step = 1'b1;
    m_sweep     = 1'b0;
  endtask

  task automatic tick();
    bit adv;
    @(posedge clk);
    if (reset === 1'b1) begin
      adv = 1'b0;
      if (run) begin
        m_streak++;
        adv = (m_streak % TICK) == 0;
      end else begin
        m_streak = 0;
        adv = step && !m_prev_step;
      end
      m_prev_step = step;
      m_sweep     = adv && (m_addr == NADR - 1);
      if (adv) m_addr = (m_addr + 1) % NADR;
      m_since = adv ? 0 : ((m_since < 10) ? m_since + 1 : m_since);
    end
    #1;
    if (reset === 1'b1 && chk_en) begin
      check("rd_addr", 32'(rd_addr), 32'(m_addr));
      check("sweep_done", 32'(sweep_done), 32'(m_sweep));
      check("disp_valid", 32'(disp_valid), 32'(m_since >= 2));
      if (m_since >= 2) begin
        check("disp_addr", 32'(disp_addr), 32'(m_addr));
        check("disp_data", 32'(disp_data), 32'(mem[m_addr]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    for (int i = 0; i < NADR; i++) mem[i] = DW'(i) ^ 4'hA;
    reset = 1'b0;
    run   = 1'b0;
    step  = 1'b1;
    model_reset();

    // Reset held with step high
    repeat (3) begin
      tick();
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_disp_addr", 32'(disp_addr), 0);
      check("rst_disp_data", 32'(disp_data), 0);
      check("rst_valid", 32'(disp_valid), 0);
      check("rst_sweep", 32'(sweep_done), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tick();
    check("post_rst_valid1", 32'(disp_valid), 0);
    tick();
    check("post_rst_valid2", 32'(disp_valid), 1);
    check("post_rst_addr", 32'(rd_addr), 0);
    tick();

    // Running through one full sweep
    step   = 1'b0;
    run    = 1'b1;
    pulses = 0;
    for (int i = 1; i <= TICK * NADR; i++) begin
      tick();
      if (i == TICK) check("first_advance", 32'(rd_addr), 1);
      if (i == TICK + 2) begin
        check("adv1_disp_addr", 32'(disp_addr), 1);
        check("adv1_disp_data", 32'(disp_data), 32'hB);
      end
      if (sweep_done) begin
        pulses++;
        check("sweep_addr", 32'(rd_addr), 0);
        check("sweep_cycle", 32'(i), 32'(TICK * NADR));
      end
    end
    check("sweep_pulses", 32'(pulses), 1);

    // Paused single-stepping
    run = 1'b0;
    repeat (3) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end
    check("three_steps", 32'(rd_addr), 3);
    step = 1'b1;
    repeat (10) tick();
    step = 1'b0;
    tick();
    check("held_step", 32'(rd_addr), 4);
    repeat (20) tick();
    check("idle_hold", 32'(rd_addr), 4);

    // RAM write under a paused display
    mem[4] = 4'h5;
    chk_en = 1'b0;
    tick();
    chk_en = 1'b1;
    check("wr_valid", 32'(disp_valid), 1);
    check("wr_addr", 32'(disp_addr), 4);
    tick();
    check("wr_data", 32'(disp_data), 32'h5);
    check("wr_valid2", 32'(disp_valid), 1);

    // Randomized run/step activity
    repeat (600) begin
      if ($urandom_range(15) == 0) run = ~run;
      if ($urandom_range(3) == 0) step = ~step;
      tick();
    end

    // Async reset mid-cycle while running
    run  = 1'b1;
    step = 1'b0;
    for (int k = 0; k < 400 && rd_addr != 5'd7; k++) tick();
    check("reach_7", 32'(rd_addr), 7);
    #2 reset = 1'b0;
    #1;
    check("async_addr", 32'(rd_addr), 0);
    check("async_valid", 32'(disp_valid), 0);
    check("async_disp_addr", 32'(disp_addr), 0);
    model_reset();
    #2 reset = 1'b1;
    repeat (TICK - 1) tick();
    check("post_async_hold", 32'(rd_addr), 0);
    tick();
    check("post_async_adv", 32'(rd_addr), 1);
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
